// File: rtl/exc_pkg.sv
// Shared types and helpers for the exception sequencer.
// Includes the FSM state enum, the default source count and the cause encoder.
package exc_pkg;

  localparam int unsigned NSRC_DEF = 3;
  localparam int unsigned XLEN     = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    SERVICE = 2'd2,
    RETURN  = 2'd3
  } exc_state_e;

  // Cause word for winner id: {29'b0, id>=2, id>=1, 1'b1}
  function automatic logic [XLEN-1:0] cause_enc(input int unsigned id);
    cause_enc = {29'b0, (id >= 32'd2), (id >= 32'd1), 1'b1};
  endfunction

endpackage

// File: rtl/exc_sequencer_if.sv
// Exception sequencer bus: source/pipeline inputs and CP0-facing outputs.
// slave = sequencer side, master = sources/pipeline/CP0 side.
interface exc_sequencer_if #(
  parameter int unsigned NSRC = exc_pkg::NSRC_DEF
);

  logic [NSRC-1:0] exp_src;
  logic [NSRC-1:0] src_mask;
  logic            glb_block;
  logic [31:0]     pc_cur;
  logic            is_eret;
  logic            pipe_ready;

  logic            exc_take;
  logic [31:0]     exc_vec;
  logic [31:0]     cause_out;
  logic [31:0]     epc_out;
  logic            eret_redir;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] in_service;
  logic            busy;

  modport master (
    output exp_src, src_mask, glb_block, pc_cur, is_eret, pipe_ready,
    input  exc_take, exc_vec, cause_out, epc_out, eret_redir, pending, in_service, busy
  );

  modport slave (
    input  exp_src, src_mask, glb_block, pc_cur, is_eret, pipe_ready,
    output exc_take, exc_vec, cause_out, epc_out, eret_redir, pending, in_service, busy
  );

endinterface

// File: rtl/exc_prio_enc.sv
// Priority encoder over an eligible vector; the highest set index wins.
// Purely combinational.
module exc_prio_enc #(
  parameter  int unsigned N   = 3,
  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   eligible_i,
  output logic           valid_o,
  output logic [IDW-1:0] id_o
);

  // Later (higher) indices overwrite earlier ones
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (eligible_i[i]) begin
        valid_o = 1'b1;
        id_o    = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/exc_sequencer.sv
// Exception entry/return sequencer in front of the CP0 EPC/Cause registers.
// Define EXC_NEST_EN to allow higher-priority sources to preempt a handler (EPC/id stack).
module exc_sequencer
  import exc_pkg::*;
#(
  parameter int unsigned NSRC     = NSRC_DEF,
  parameter logic [31:0] VEC_BASE = 32'h0000_4180,
  parameter logic [31:0] VEC_STEP = 32'h0000_0020
) (
  input logic            clk,
  input logic            reset,
  exc_sequencer_if.slave bus
);

  localparam int unsigned IDW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int unsigned SPW = $clog2(NSRC + 1);

  exc_state_e      state_q, state_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] in_service_q;
  logic [IDW-1:0]  cur_id_q;
  logic [31:0]     epc_q;
  logic            exc_take_q;
  logic [31:0]     exc_vec_q;
  logic [31:0]     cause_q;
  logic            eret_redir_q;
  logic            busy_q;

  logic [NSRC-1:0] eligible_c;
  logic            win_valid_c;
  logic [IDW-1:0]  win_id_c;
  logic [NSRC-1:0] win_mask_c;
  logic [NSRC-1:0] cur_mask_c;
  logic            take_ok_c;
  logic            preempt_c;
  logic            decide_c;
  logic [31:0]     vec_c;
  logic [31:0]     cause_c;

`ifdef EXC_NEST_EN
  logic [31:0]     stk_epc_q [NSRC];
  logic [IDW-1:0]  stk_id_q  [NSRC];
  logic [SPW-1:0]  sp_q;
  logic [SPW-1:0]  sp_m1_c;
`endif

  assign eligible_c = pending_q & ~bus.src_mask;

  exc_prio_enc #(.N(NSRC)) u_prio (
    .eligible_i (eligible_c),
    .valid_o    (win_valid_c),
    .id_o       (win_id_c)
  );

  assign win_mask_c = NSRC'(1) << win_id_c;
  assign cur_mask_c = NSRC'(1) << cur_id_q;
  assign take_ok_c  = win_valid_c & ~bus.glb_block & bus.pipe_ready;
  assign vec_c      = VEC_BASE + (VEC_STEP * 32'(win_id_c));
  assign cause_c    = cause_enc(32'(win_id_c));

  // An eret in the same cycle as a would-be preemption is honoured first
`ifdef EXC_NEST_EN
  assign preempt_c = (state_q == SERVICE) & ~bus.is_eret & take_ok_c & (win_id_c > cur_id_q);
  assign sp_m1_c   = sp_q - SPW'(1);
`else
  assign preempt_c = 1'b0;
`endif

  assign decide_c  = ((state_q == IDLE) & take_ok_c) | preempt_c;

  // A new request in the same cycle beats the clear of the winner
  assign pending_d = (pending_q & ~(decide_c ? win_mask_c : '0)) | bus.exp_src;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (decide_c) state_d = TAKE;
      TAKE:    state_d = SERVICE;
      SERVICE: begin
        if (bus.is_eret)     state_d = RETURN;
        else if (preempt_c)  state_d = TAKE;
      end
      RETURN: begin
`ifdef EXC_NEST_EN
        state_d = (sp_q != '0) ? SERVICE : IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      in_service_q <= '0;
      cur_id_q     <= '0;
      epc_q        <= '0;
      exc_take_q   <= 1'b0;
      exc_vec_q    <= '0;
      cause_q      <= '0;
      eret_redir_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef EXC_NEST_EN
      sp_q         <= '0;
      for (int i = 0; i < int'(NSRC); i++) begin
        stk_epc_q[i] <= '0;
        stk_id_q[i]  <= '0;
      end
`endif
    end else begin
      state_q      <= state_d;
      busy_q       <= (state_d != IDLE);
      pending_q    <= pending_d;
      exc_take_q   <= decide_c;
      eret_redir_q <= (state_q == SERVICE) & bus.is_eret;

      if (decide_c) begin
        cur_id_q     <= win_id_c;
        epc_q        <= bus.pc_cur;
        exc_vec_q    <= vec_c;
        cause_q      <= cause_c;
        in_service_q <= in_service_q | win_mask_c;
      end else if (state_q == RETURN) begin
        in_service_q <= in_service_q & ~cur_mask_c;
`ifdef EXC_NEST_EN
        // Resume the interrupted level
        if (sp_q != '0) begin
          cur_id_q <= stk_id_q[sp_m1_c];
          epc_q    <= stk_epc_q[sp_m1_c];
          sp_q     <= sp_m1_c;
        end
`endif
      end

`ifdef EXC_NEST_EN
      if (preempt_c) begin
        stk_epc_q[sp_q] <= epc_q;
        stk_id_q[sp_q]  <= cur_id_q;
        sp_q            <= sp_q + SPW'(1);
      end
`endif
    end
  end

  assign bus.exc_take   = exc_take_q;
  assign bus.exc_vec    = exc_vec_q;
  assign bus.cause_out  = cause_q;
  assign bus.epc_out    = epc_q;
  assign bus.eret_redir = eret_redir_q;
  assign bus.pending    = pending_q;
  assign bus.in_service = in_service_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer with take/redirect scoreboards.
// Covers EXC_NEST_EN when the macro is defined for the build.
module tb_exc_sequencer;

  localparam logic [31:0] VB = 32'h0000_4180;
  localparam logic [31:0] VS = 32'h0000_0020;

  typedef struct {
    logic [31:0] vec;
    logic [31:0] cause;
  } take_t;

  logic clk;
  logic reset;

  exc_sequencer_if #(.NSRC(3)) bus ();

  exc_sequencer #(.NSRC(3), .VEC_BASE(VB), .VEC_STEP(VS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  take_t       take_sb[$];
  logic [31:0] redir_sb[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic take_t mk_take(input int unsigned id);
    take_t t;
    t.vec   = VB + VS * id;
    t.cause = (id == 2) ? 32'h7 : (id == 1) ? 32'h3 : 32'h1;
    return t;
  endfunction

  // Step until exc_take (bounded), then compare against the scoreboard head
  task automatic wait_take(input string tag, input int max);
    take_t t;
    int    cyc;
    cyc = 0;
    while (bus.exc_take !== 1'b1 && cyc < max) begin
      step();
      cyc++;
    end
    chk({tag, "_take_seen"}, 32'(bus.exc_take), 32'h1);
    if (bus.exc_take === 1'b1) begin
      chk({tag, "_sb_nonempty"}, 32'(take_sb.size() != 0), 32'h1);
      if (take_sb.size() != 0) begin
        t = take_sb.pop_front();
        chk({tag, "_vec"},   bus.exc_vec,   t.vec);
        chk({tag, "_cause"}, bus.cause_out, t.cause);
      end
    end
  endtask

  // Move into SERVICE, issue one eret, check the redirect pulse and target
  task automatic do_eret(input string tag);
    logic [31:0] e;
    step();
    bus.is_eret = 1'b1;
    step();
    bus.is_eret = 1'b0;
    chk({tag, "_redir"}, 32'(bus.eret_redir), 32'h1);
    if (redir_sb.size() != 0) begin
      e = redir_sb.pop_front();
      chk({tag, "_epc"}, bus.epc_out, e);
    end
    step();
    chk({tag, "_redir_pulse"}, 32'(bus.eret_redir), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.exp_src    = '0;
    bus.src_mask   = '0;
    bus.glb_block  = 1'b0;
    bus.pc_cur     = '0;
    bus.is_eret    = 1'b0;
    bus.pipe_ready = 1'b1;
    reset          = 1'b1;
    step();
    step();
    chk("rst_busy",       32'(bus.busy),       32'h0);
    chk("rst_take",       32'(bus.exc_take),   32'h0);
    chk("rst_pending",    32'(bus.pending),    32'h0);
    chk("rst_in_service", 32'(bus.in_service), 32'h0);
    chk("rst_cause",      bus.cause_out,       32'h0);
    chk("rst_epc",        bus.epc_out,         32'h0);
    reset = 1'b0;
    step();

    // 1: single source 2, take latency two cycles
    bus.pc_cur  = 32'h1234_5678;
    bus.exp_src = 3'b100;
    take_sb.push_back(mk_take(2));
    step();
    bus.exp_src = '0;
    chk("t1_pending",  32'(bus.pending),  32'h4);
    chk("t1_no_take",  32'(bus.exc_take), 32'h0);
    step();
    chk("t1_take_c2",  32'(bus.exc_take), 32'h1);
    wait_take("t1", 0);
    chk("t1_in_service", 32'(bus.in_service), 32'h4);
    chk("t1_pend_clr",   32'(bus.pending),    32'h0);
    bus.pc_cur = 32'hDEAD_0000;
    redir_sb.push_back(32'h1234_5678);
    do_eret("t1");
    chk("t1_idle",   32'(bus.busy),       32'h0);
    chk("t1_is_clr", 32'(bus.in_service), 32'h0);

    // 2: all three together, taken 2,1,0
    bus.pc_cur  = 32'h0000_0100;
    bus.exp_src = 3'b111;
    for (int i = 2; i >= 0; i--) begin
      take_sb.push_back(mk_take(i));
      redir_sb.push_back(32'h0000_0100);
    end
    step();
    bus.exp_src = '0;
    chk("t2_pending", 32'(bus.pending), 32'h7);
    wait_take("t2a", 4);
    do_eret("t2a");
    wait_take("t2b", 4);
    do_eret("t2b");
    wait_take("t2c", 4);
    chk("t2_drained", 32'(bus.pending), 32'h0);
    do_eret("t2c");

    // 3: masked source persists, taken once unmasked
    bus.src_mask = 3'b001;
    bus.exp_src  = 3'b001;
    bus.pc_cur   = 32'h0000_0300;
    step();
    bus.exp_src = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_masked_no_take", 32'(bus.exc_take), 32'h0);
    end
    chk("t3_pending", 32'(bus.pending), 32'h1);
    bus.src_mask = '0;
    take_sb.push_back(mk_take(0));
    redir_sb.push_back(32'h0000_0300);
    wait_take("t3", 2);
    do_eret("t3");

    // 4: glb_block and pipe_ready hold the decision
    bus.glb_block = 1'b1;
    bus.exp_src   = 3'b010;
    bus.pc_cur    = 32'h0000_0400;
    step();
    bus.exp_src = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_block_no_take", 32'(bus.exc_take), 32'h0);
    end
    bus.glb_block  = 1'b0;
    bus.pipe_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_stall_no_take", 32'(bus.exc_take), 32'h0);
    end
    chk("t4_pending", 32'(bus.pending), 32'h2);
    chk("t4_not_busy", 32'(bus.busy), 32'h0);
    bus.pipe_ready = 1'b1;
    take_sb.push_back(mk_take(1));
    redir_sb.push_back(32'h0000_0400);
    wait_take("t4", 1);
    do_eret("t4");

    // 5: reset while in SERVICE
    bus.exp_src = 3'b001;
    take_sb.push_back(mk_take(0));
    step();
    bus.exp_src = '0;
    wait_take("t5", 3);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_busy",       32'(bus.busy),       32'h0);
    chk("t5_pending",    32'(bus.pending),    32'h0);
    chk("t5_in_service", 32'(bus.in_service), 32'h0);
    chk("t5_redir",      32'(bus.eret_redir), 32'h0);
    step();
    chk("t5_redir_after", 32'(bus.eret_redir), 32'h0);
    chk("t5_take_after",  32'(bus.exc_take),   32'h0);

    // 6: higher source arriving during service of source 0
    bus.pc_cur  = 32'hAAAA_0000;
    bus.exp_src = 3'b001;
    take_sb.push_back(mk_take(0));
    step();
    bus.exp_src = '0;
    wait_take("t6a", 3);
    step();
    bus.pc_cur  = 32'hBBBB_0000;
    bus.exp_src = 3'b100;
    step();
    bus.exp_src = '0;
`ifdef EXC_NEST_EN
    take_sb.push_back(mk_take(2));
    wait_take("t6b", 3);
    chk("t6_nested_is", 32'(bus.in_service), 32'h5);
    redir_sb.push_back(32'hBBBB_0000);
    redir_sb.push_back(32'hAAAA_0000);
    do_eret("t6b");
    chk("t6_resume_is", 32'(bus.in_service), 32'h1);
    do_eret("t6a");
`else
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_preempt", 32'(bus.exc_take), 32'h0);
    end
    chk("t6_pending", 32'(bus.pending), 32'h4);
    redir_sb.push_back(32'hAAAA_0000);
    do_eret("t6a");
    take_sb.push_back(mk_take(2));
    redir_sb.push_back(32'hBBBB_0000);
    wait_take("t6b", 3);
    do_eret("t6b");
`endif
    chk("t6_idle", 32'(bus.busy), 32'h0);
    chk("sb_take_empty",  32'(take_sb.size()),  32'h0);
    chk("sb_redir_empty", 32'(redir_sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
